css_mcu0_dmi_req_arbiter: RTL and testbench

Shares the single MCU DMI upstream port between two debug requesters: port 0 is the JTAG DTM and port 1 is the SoC-side debug master. Each requester submits one DMI command at a time over a valid/ready handshake. The block arbitrates round-robin and replays the winning command as a registered single-cycle `dmi_en` pulse into the DMI core/uncore mux. After a fixed read latency it captures `dmi_rdata` and returns it as a one-cycle response to the requester that owns the command.

---
 rtl/css_mcu0_dmi_arb_pkg.sv | 19 +
 rtl/css_mcu0_dmi_rr_pick.sv | 16 +
 rtl/css_mcu0_dmi_req_arbiter.sv | 136 +++++++++++++
 tb/tb_css_mcu0_dmi_req_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/css_mcu0_dmi_arb_pkg.sv
// Shared types and constants for the MCU DMI request arbiter.
package css_mcu0_dmi_arb_pkg;

  localparam int unsigned DMI_AW = 7;
  localparam int unsigned DMI_DW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } dmi_arb_state_e;

  typedef struct packed {
    logic              wr_en;
    logic [DMI_AW-1:0] addr;
    logic [DMI_DW-1:0] wdata;
  } dmi_cmd_t;

endpackage

// File: rtl/css_mcu0_dmi_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// port that was not granted last. Purely combinational.
module css_mcu0_dmi_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant from the request vector and the previous winner
  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | last_grant);
    grant[1] = valid[1] & (~valid[0] | ~last_grant);
  end

endmodule

// File: rtl/css_mcu0_dmi_req_arbiter.sv
// Shares the MCU DMI upstream port between the JTAG DTM (port 0) and the SoC
// debug master (port 1). One command in flight; the winner is replayed as a
// single-cycle dmi_en pulse and its read data returned RD_LAT cycles later.
module css_mcu0_dmi_req_arbiter
  import css_mcu0_dmi_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_l,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wr_en,
  input  logic [DMI_AW-1:0] req0_addr,
  input  logic [DMI_DW-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DMI_DW-1:0] rsp0_rdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wr_en,
  input  logic [DMI_AW-1:0] req1_addr,
  input  logic [DMI_DW-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DMI_DW-1:0] rsp1_rdata,

  output logic              dmi_en,
  output logic              dmi_wr_en,
  output logic [DMI_AW-1:0] dmi_addr,
  output logic [DMI_DW-1:0] dmi_wdata,
  input  logic [DMI_DW-1:0] dmi_rdata,

  output logic              busy
);

  localparam logic [1:0] LatInit = 2'(RD_LAT);

  dmi_arb_state_e    state_q;
  dmi_cmd_t          cmd_q;
  dmi_cmd_t          acc_cmd;
  logic              owner_q;
  logic              last_grant_q;
  logic [1:0]        lat_cnt_q;
  logic              dmi_en_q;
  logic              dmi_wr_en_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [DMI_DW-1:0] rsp0_rdata_q;
  logic [DMI_DW-1:0] rsp1_rdata_q;

  logic [1:0]        req_valid;
  logic [1:0]        grant;
  logic              accept;
  logic              capture;
  logic [DMI_DW-1:0] cap_data;

  assign req_valid = {req1_valid, req0_valid};

  css_mcu0_dmi_rr_pick u_rr_pick (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Handshake, winner payload mux and read-data capture decode
  always_comb begin
    req0_ready    = (state_q == StIdle) & grant[0];
    req1_ready    = (state_q == StIdle) & grant[1];
    accept        = req0_ready | req1_ready;
    acc_cmd.wr_en = grant[1] ? req1_wr_en : req0_wr_en;
    acc_cmd.addr  = grant[1] ? req1_addr  : req0_addr;
    acc_cmd.wdata = grant[1] ? req1_wdata : req0_wdata;
    // Zero latency samples in the strobe cycle itself; otherwise the last WAIT cycle
    capture       = ((state_q == StIssue) && (RD_LAT == 0)) ||
                    ((state_q == StWait) && (lat_cnt_q == 2'd1));
    cap_data      = cmd_q.wr_en ? '0 : dmi_rdata;
  end

  // Command FSM with registered strobe and response outputs
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lat_cnt_q    <= 2'd0;
      dmi_en_q     <= 1'b0;
      dmi_wr_en_q  <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      dmi_en_q     <= 1'b0;
      dmi_wr_en_q  <= 1'b0;
      rsp0_valid_q <= capture & ~owner_q;
      rsp1_valid_q <= capture & owner_q;
      if (capture && !owner_q) rsp0_rdata_q <= cap_data;
      if (capture && owner_q)  rsp1_rdata_q <= cap_data;

      case (state_q)
        StIdle: begin
          if (accept) begin
            cmd_q        <= acc_cmd;
            owner_q      <= grant[1];
            last_grant_q <= grant[1];
            dmi_en_q     <= 1'b1;
            dmi_wr_en_q  <= acc_cmd.wr_en;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          lat_cnt_q <= LatInit;
          state_q   <= (RD_LAT == 0) ? StIdle : StWait;
        end
        StWait: begin
          lat_cnt_q <= lat_cnt_q - 2'd1;
          if (lat_cnt_q == 2'd1) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dmi_en     = dmi_en_q;
  assign dmi_wr_en  = dmi_wr_en_q;
  assign dmi_addr   = cmd_q.addr;
  assign dmi_wdata  = cmd_q.wdata;
  assign busy       = (state_q != StIdle);
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_css_mcu0_dmi_req_arbiter.sv
// Directed bench for the DMI request arbiter. Three instances share stimulus:
// index 0 uses RD_LAT=1, index 1 uses RD_LAT=3, index 2 uses RD_LAT=0. Each
// scenario resets all instances and checks only the instance it targets.
module tb_css_mcu0_dmi_req_arbiter;

  logic        clk;
  logic        rst_l;
  logic        req0_valid, req0_wr_en;
  logic [6:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_wr_en;
  logic [6:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic [31:0] dmi_rdata;

  logic [2:0]  r0rdy, r1rdy, r0v, r1v, den, dwe, bsy;
  logic [31:0] r0d [3];
  logic [31:0] r1d [3];
  logic [31:0] dwd [3];
  logic [6:0]  dad [3];

  int n_pass  = 0;
  int n_total = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    css_mcu0_dmi_req_arbiter #(.RD_LAT(Lat)) u_dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .req0_valid (req0_valid),
      .req0_ready (r0rdy[g]),
      .req0_wr_en (req0_wr_en),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .rsp0_valid (r0v[g]),
      .rsp0_rdata (r0d[g]),
      .req1_valid (req1_valid),
      .req1_ready (r1rdy[g]),
      .req1_wr_en (req1_wr_en),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .rsp1_valid (r1v[g]),
      .rsp1_rdata (r1d[g]),
      .dmi_en     (den[g]),
      .dmi_wr_en  (dwe[g]),
      .dmi_addr   (dad[g]),
      .dmi_wdata  (dwd[g]),
      .dmi_rdata  (dmi_rdata),
      .busy       (bsy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req0_wr_en = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_wr_en = 1'b0; req1_addr = '0; req1_wdata = '0;
    dmi_rdata  = '0;
    rst_l = 1'b0;
    @(negedge clk);
    #1 rst_l = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_rdy;

    // ---- Reset values ----
    do_reset();
    rst_l = 1'b0;
    #1;
    chk("reset_ctrl", 32'({r0rdy[0], r1rdy[0], r0v[0], r1v[0], den[0], dwe[0], bsy[0]}), 32'h0);
    chk("reset_addr", 32'(dad[0]), 32'h0);
    chk("reset_wdata", dwd[0], 32'h0);
    chk("reset_rdata", r0d[0] | r1d[0], 32'h0);

    // ---- RD_LAT=1 single read from port 0 ----
    do_reset();
    @(negedge clk); req0_valid = 1'b1; req0_addr = 7'h04; #1;       // T
    chk("t1_ready0", 32'(r0rdy[0]), 32'h1);
    @(negedge clk); req0_valid = 1'b0; #1;                           // T+1
    chk("t1_en", 32'({den[0], dwe[0], bsy[0]}), 32'h5);
    chk("t1_addr", 32'(dad[0]), 32'h04);
    @(negedge clk); dmi_rdata = 32'hA5A5_0001; #1;                   // T+2 capture
    chk("t1_en_off", 32'({den[0], r0v[0]}), 32'h0);
    @(negedge clk); dmi_rdata = 32'h0; #1;                           // T+3
    chk("t1_rsp0", 32'({r0v[0], r1v[0], bsy[0]}), 32'h4);
    chk("t1_rdata", r0d[0], 32'hA5A5_0001);
    @(negedge clk); #1;
    chk("t1_pulse", 32'({r0v[0], r1v[0]}), 32'h0);
    chk("t1_hold", r0d[0], 32'hA5A5_0001);

    // ---- Tie: port 0 read 0x11, port 1 write 0x50 ----
    do_reset();
    dmi_rdata = 32'h1234_5678;
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 7'h11;
    req1_valid = 1'b1; req1_wr_en = 1'b1; req1_addr = 7'h50; req1_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t2_grant", 32'({r1rdy[0], r0rdy[0]}), 32'h1);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("t2_issue0", 32'({den[0], dwe[0], r1rdy[0]}), 32'h4);
    chk("t2_addr0", 32'(dad[0]), 32'h11);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t2_rsp0", 32'({r0v[0], r1v[0]}), 32'h2);
    chk("t2_rdata0", r0d[0], 32'h1234_5678);
    chk("t2_ready1", 32'(r1rdy[0]), 32'h1);
    @(negedge clk); req1_valid = 1'b0; #1;
    chk("t2_issue1", 32'({den[0], dwe[0]}), 32'h3);
    chk("t2_addr1", 32'(dad[0]), 32'h50);
    chk("t2_wdata1", dwd[0], 32'hDEAD_BEEF);
    @(negedge clk); #1;
    chk("t2_wr_gated", 32'({den[0], dwe[0]}), 32'h0);
    @(negedge clk); #1;
    chk("t2_rsp1", 32'({r0v[0], r1v[0]}), 32'h1);
    chk("t2_rdata1", r1d[0], 32'h0);

    // ---- Both hold valid for 6 commands: alternate 0,1,... every 3 cycles ----
    do_reset();
    req0_wr_en = 1'b0; req0_addr = 7'h20;
    req1_wr_en = 1'b0; req1_addr = 7'h21;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); req0_valid = 1'b1; req1_valid = 1'b1; #1;
      exp_rdy = 2'b00;
      if (i % 3 == 0) exp_rdy = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("t3_ready_c%0d", i), 32'({r1rdy[0], r0rdy[0]}), 32'(exp_rdy));
      if (i % 3 == 1)
        chk($sformatf("t3_addr_c%0d", i), 32'(dad[0]), ((i / 3) % 2 == 0) ? 32'h20 : 32'h21);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // ---- RD_LAT=3, port 1 alone, 4 back-to-back reads ----
    do_reset();
    req1_wr_en = 1'b0; req1_addr = 7'h30;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      req1_valid = (i < 20);
      dmi_rdata  = 32'hC000_0000 + 32'(i);
      #1;
      chk($sformatf("t4_ready_c%0d", i), 32'(r1rdy[1]), (i % 5 == 0 && i < 20) ? 32'h1 : 32'h0);
      chk($sformatf("t4_rsp_c%0d", i), 32'(r1v[1]), (i % 5 == 0 && i > 0) ? 32'h1 : 32'h0);
      if (i % 5 == 0 && i > 0)
        chk($sformatf("t4_rdata_c%0d", i), r1d[1], 32'hC000_0000 + 32'(i - 1));
    end
    req1_valid = 1'b0;

    // ---- Reset pulse during WAIT ----
    do_reset();
    @(negedge clk); req0_valid = 1'b1; req0_addr = 7'h05; dmi_rdata = 32'h5555_AAAA; #1;
    chk("t5_ready0", 32'(r0rdy[0]), 32'h1);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("t5_en", 32'(den[0]), 32'h1);
    @(negedge clk); #1;
    rst_l = 1'b0;
    #1;
    chk("t5_async_ctrl", 32'({r0rdy[0], r1rdy[0], r0v[0], r1v[0], den[0], dwe[0], bsy[0]}), 32'h0);
    chk("t5_async_addr", 32'(dad[0]), 32'h0);
    @(negedge clk); #1;
    chk("t5_no_rsp_a", 32'({r0v[0], r1v[0]}), 32'h0);
    rst_l = 1'b1;
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 7'h06; req1_wr_en = 1'b0; dmi_rdata = 32'h0BAD_F00D;
    #1;
    chk("t5_no_rsp_b", 32'({r0v[0], r1v[0], bsy[0]}), 32'h0);
    chk("t5_ready1", 32'(r1rdy[0]), 32'h1);
    @(negedge clk); req1_valid = 1'b0; #1;
    chk("t5_en2", 32'(den[0]), 32'h1);
    chk("t5_addr2", 32'(dad[0]), 32'h06);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t5_rsp1", 32'({r0v[0], r1v[0]}), 32'h1);
    chk("t5_rdata1", r1d[0], 32'h0BAD_F00D);

    // ---- RD_LAT=0: sample in the dmi_en cycle, response 2 cycles after accept ----
    do_reset();
    @(negedge clk); req0_valid = 1'b1; req0_addr = 7'h07; #1;
    chk("t6_ready0", 32'(r0rdy[2]), 32'h1);
    @(negedge clk); req0_valid = 1'b0; dmi_rdata = 32'h7777_0000; #1;
    chk("t6_en", 32'({den[2], bsy[2], r0v[2]}), 32'h6);
    @(negedge clk); dmi_rdata = 32'h0; #1;
    chk("t6_rsp0", 32'({r0v[2], bsy[2]}), 32'h2);
    chk("t6_rdata0", r0d[2], 32'h7777_0000);
    @(negedge clk); #1;
    chk("t6_pulse", 32'(r0v[2]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
